// File: rtl/seg7_pkg.sv
// seg7_pkg: BCD digit type, digit limit and active-low seven-segment glyphs
package seg7_pkg;
    typedef logic [3:0] bcd_t;
    localparam bcd_t BCD_MAX = 4'd9;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    // Codes 10-15 never occur in a valid count; show them as blank.
    function automatic logic [6:0] seg7_decode(input bcd_t d);
        case (d)
            4'd0: return SEG_0;
            4'd1: return SEG_1;
            4'd2: return SEG_2;
            4'd3: return SEG_3;
            4'd4: return SEG_4;
            4'd5: return SEG_5;
            4'd6: return SEG_6;
            4'd7: return SEG_7;
            4'd8: return SEG_8;
            4'd9: return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one decade of the BCD counter with combinational carry out
module bcd_digit
    import seg7_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output bcd_t q,
    output logic carry
);
    assign carry = inc & (q == BCD_MAX);
    // Clear wins over increment; 9 rolls to 0 and hands the carry upward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 4'd0;
        else if (clr) q <= 4'd0;
        else if (inc) q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
    end
endmodule

// File: rtl/match_event_counter.sv
// match_event_counter: counts det high runs in 4-digit BCD and drives a muxed 7-seg display
module match_event_counter
    import seg7_pkg::*;
#(
    parameter int REFRESH_BITS = 16,
    parameter bit BLANK_LZ     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        det,
    input  logic        en,
    input  logic        clr,
    output logic [15:0] count_bcd,
    output logic        ovf,
    output logic [6:0]  seg,
    output logic [3:0]  an
);
    logic                    r_det_q;
    logic                    r_det_qq;
    logic                    r_primed;
    logic [REFRESH_BITS-1:0] r_refresh;
    logic                    w_rise;
    logic [3:0]              w_inc;
    logic [3:0]              w_carry;
    logic [3:0]              w_blank;
    logic [1:0]              w_sel;
    bcd_t                    w_dig [4];

    // Edge detect; on the first edge after reset both stages load det so a
    // det already high at reset release is not mistaken for a new match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_primed <= 1'b0;
            r_det_q  <= 1'b0;
            r_det_qq <= 1'b0;
        end else begin
            r_primed <= 1'b1;
            r_det_q  <= det;
            r_det_qq <= r_primed ? r_det_q : det;
        end
    end

    assign w_rise     = r_det_q & ~r_det_qq;
    assign w_inc[0]   = w_rise & en;
    assign w_inc[3:1] = w_carry[2:0];

    genvar d;
    generate
        for (d = 0; d < 4; d++) begin : g_dig
            bcd_digit u_dig (
                .clk   (clk),
                .rst   (rst),
                .clr   (clr),
                .inc   (w_inc[d]),
                .q     (w_dig[d]),
                .carry (w_carry[d])
            );
        end
    endgenerate

    assign count_bcd = {w_dig[3], w_dig[2], w_dig[1], w_dig[0]};

    // Sticky overflow on a thousands-digit carry (9999 -> 0000).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf <= 1'b0;
        else if (clr) ovf <= 1'b0;
        else if (w_carry[3]) ovf <= 1'b1;
    end

    // Free-running refresh counter; its top two bits pick the lit digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_refresh <= '0;
        else r_refresh <= r_refresh + 1'b1;
    end

    assign w_sel      = r_refresh[REFRESH_BITS-1 -: 2];
    assign w_blank[3] = BLANK_LZ && (w_dig[3] == 4'd0);
    assign w_blank[2] = w_blank[3] && (w_dig[2] == 4'd0);
    assign w_blank[1] = w_blank[2] && (w_dig[1] == 4'd0);
    assign w_blank[0] = 1'b0;

    // Registered anode and segment drive for the currently selected digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1110;
            seg <= SEG_0;
        end else begin
            an  <= ~(4'b0001 << w_sel);
            seg <= w_blank[w_sel] ? SEG_BLANK : seg7_decode(w_dig[w_sel]);
        end
    end
endmodule

// File: tb/tb_match_event_counter.sv
// tb_match_event_counter: directed stimulus against a cycle model of the match counter
module tb_match_event_counter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        det = 1'b0;
    logic        en  = 1'b1;
    logic        clr = 1'b0;
    logic [15:0] count_bcd;
    logic        ovf;
    logic [6:0]  seg;
    logic [3:0]  an;
    int          n_chk = 0;
    int          n_fail = 0;

    localparam logic [6:0] GLYPH [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    match_event_counter #(.REFRESH_BITS(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .det(det), .en(en), .clr(clr),
        .count_bcd(count_bcd), .ovf(ovf), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int c);
        return 16'(((c / 1000) % 10) * 4096 + ((c / 100) % 10) * 256 + ((c / 10) % 10) * 16 + c % 10);
    endfunction

    function automatic logic [6:0] glyph_for(input int c, input int k);
        int p;
        p = (k == 0) ? 1 : (k == 1) ? 10 : (k == 2) ? 100 : 1000;
        if (k > 0 && c < p) return 7'b1111111;
        return GLYPH[(c / p) % 10];
    endfunction

    // Model: integer count, det samples taken since reset, display one cycle late.
    int         m_cnt, m_ref, m_n;
    logic       m_ovf, m_s1, m_s0, m_rise;
    logic [3:0] m_an;
    logic [6:0] m_seg;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_ovf = 0; m_ref = 0; m_n = 0; m_s1 = 0; m_s0 = 0;
            m_an = 4'b1110; m_seg = 7'b1000000;
        end else begin
            m_an  = ~(4'b0001 << (m_ref / 4));
            m_seg = glyph_for(m_cnt, m_ref / 4);
            m_ref = (m_ref + 1) % 16;
            m_rise = (m_n >= 2) && m_s1 && !m_s0;
            if (clr) begin
                m_cnt = 0; m_ovf = 0;
            end else if (m_rise && en) begin
                if (m_cnt == 9999) begin
                    m_cnt = 0; m_ovf = 1;
                end else m_cnt++;
            end
            m_s0 = m_s1; m_s1 = det;
            if (m_n < 2) m_n++;
        end
    end

    always @(negedge clk) begin
        check("cmp_count", count_bcd, to_bcd(m_cnt));
        check("cmp_ovf", ovf, m_ovf);
        check("cmp_an", an, m_an);
        check("cmp_seg", seg, m_seg);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            det = 1'b1; tick(1);
            det = 1'b0; tick(1);
        end
    endtask

    task automatic do_clr();
        clr = 1'b1; tick(1);
        clr = 1'b0;
    endtask

    logic [3:0] prev;
    logic       found;
    localparam logic [3:0] AN_EXP [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    localparam logic [6:0] SEG_EXP [4] = '{7'b1000000, 7'b0011001, 7'b1111111, 7'b1111111};

    initial begin
        #1 rst = 1'b1;
        #1;
        check("reset_count", count_bcd, 16'h0000);
        check("reset_ovf", ovf, 1'b0);
        check("reset_an", an, 4'b1110);
        check("reset_seg", seg, 7'b1000000);
        tick(2);
        rst = 1'b0;
        tick(3);
        // one run of 5 high cycles -> exactly one count, two edges after the rise
        det = 1'b1; tick(1);
        check("lat_edge1", count_bcd, 16'h0000);
        tick(1);
        check("lat_edge2", count_bcd, 16'h0001);
        tick(3);
        det = 1'b0; tick(3);
        check("hold_high", count_bcd, 16'h0001);
        // decade carries
        do_clr();
        pulses(998);
        check("c0998", count_bcd, 16'h0998);
        pulses(1);
        check("c0999", count_bcd, 16'h0999);
        pulses(1);
        check("c1000", count_bcd, 16'h1000);
        check("c1000_ovf", ovf, 1'b0);
        pulses(8999);
        check("c9999", count_bcd, 16'h9999);
        check("c9999_ovf", ovf, 1'b0);
        pulses(1);
        check("wrap_count", count_bcd, 16'h0000);
        check("wrap_ovf", ovf, 1'b1);
        pulses(1);
        check("after_wrap", count_bcd, 16'h0001);
        check("ovf_sticky", ovf, 1'b1);
        do_clr(); tick(1);
        check("clr_count", count_bcd, 16'h0000);
        check("clr_ovf", ovf, 1'b0);
        // rises while disabled are discarded
        en = 1'b0; pulses(3);
        check("en_off", count_bcd, 16'h0000);
        en = 1'b1; pulses(1);
        check("en_on", count_bcd, 16'h0001);
        // clear coincident with a rise wins
        det = 1'b1; tick(1);
        clr = 1'b1; tick(1);
        clr = 1'b0; det = 1'b0; tick(3);
        check("clr_vs_rise", count_bcd, 16'h0000);
        // display scan of 0040 with leading-zero blanking
        pulses(40);
        check("c0040", count_bcd, 16'h0040);
        found = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            prev = an; @(negedge clk);
            if (prev == 4'b0111 && an == 4'b1110) found = 1'b1;
        end
        check("scan_align", found, 1'b1);
        if (found) begin
            for (int i = 0; i < 16; i++) begin
                check("scan_an", an, AN_EXP[i / 4]);
                check("scan_seg", seg, SEG_EXP[i / 4]);
                tick(1);
            end
        end
        // asynchronous reset between edges
        do_clr();
        pulses(123);
        check("c0123", count_bcd, 16'h0123);
        #2 rst = 1'b1;
        #1;
        check("arst_count", count_bcd, 16'h0000);
        check("arst_an", an, 4'b1110);
        check("arst_seg", seg, 7'b1000000);
        det = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(4);
        check("det_across_rst", count_bcd, 16'h0000);
        det = 1'b0; tick(2);
        pulses(1);
        check("post_rst_pulse", count_bcd, 16'h0001);
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
